fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded by reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: byte address of the requested word, equal to pc.
REQ-006 The block SHALL have port imem_ack, input, 1 bit: the read completes this cycle, and imem_rdata is valid.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: the fetched instruction word.
REQ-008 The block SHALL have port instruction, output, 32 bits: the registered instruction presented to the control decoder and datapath.
REQ-009 The block SHALL have port instr_valid, output, 1 bit: the instruction output holds a valid, unconsumed word.
REQ-010 The block SHALL have port instr_ready, input, 1 bit: downstream consumes instruction this cycle.
REQ-011 The block SHALL have port pc, output, 32 bits: the address of the word currently fetched or held.
REQ-012 The block SHALL have port pc_plus4, output, 32 bits: pc + 4 (combinational, modulo 2^32).
REQ-013 The block SHALL have port Jump, input, 1 bit: the decoder's jump indication for the held instruction.
REQ-014 The block SHALL have port beq, input, 1 bit: the decoder's beq indication (active-high).
REQ-015 The block SHALL have port bne, input, 1 bit: the decoder's bne indication, ACTIVE-LOW (0 = bne instruction).
REQ-016 The block SHALL have port zero, input, 1 bit: the ALU zero flag for the held instruction.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, FETCH and HOLD.
REQ-018 From IDLE, the FSM SHALL move to FETCH unconditionally on the next edge.
REQ-019 In FETCH, imem_req SHALL be 1; imem_addr=pc SHALL be held stable until imem_ack.
REQ-020 In FETCH, when imem_ack=1, the block SHALL capture imem_rdata into instruction and go to HOLD; ack may arrive in the first FETCH cycle (zero wait).
REQ-021 In HOLD, imem_req SHALL be 0 and instr_valid SHALL be 1; instruction and pc SHALL stay constant while instr_ready=0.
REQ-022 In HOLD, when instr_ready=1, the block SHALL load the next PC on that edge and go to FETCH.
REQ-023 The Jump, beq, bne and zero inputs SHALL be sampled only in the HOLD-and-instr_ready cycle; they are ignored otherwise.
REQ-024 Next PC when Jump=1 SHALL be {pc_plus4[31:28], instruction[25:0], 2'b00}.
REQ-025 Next PC when Jump=0 and taken=1 SHALL be pc_plus4 + (sign-extended instruction[15:0] << 2), modulo 2^32.
REQ-026 Otherwise, next PC SHALL be pc_plus4.
REQ-027 The branch-taken term SHALL be taken = (beq & zero) | (~bne & ~zero).
REQ-028 Jump SHALL take priority over any branch condition when both are asserted.
REQ-029 pc[1:0] SHALL always be 2'b00; offsets are word-scaled and RESET_PC[1:0] SHALL be forced to 00.
REQ-030 pc_plus4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-031 imem_ack outside FETCH SHALL be ignored, with no state change.
REQ-032 Throughput SHALL be 1 instruction per 2 cycles minimum (zero-wait memory, instr_ready held 1).

Reset
REQ-033 While rst_n=0, outputs SHALL be forced immediately (asynchronously): state=IDLE, pc=RESET_PC, instruction=0, instr_valid=0, imem_req=0.
REQ-034 A reset asserted mid-FETCH or mid-HOLD SHALL abandon the operation; an imem_ack arriving during or the cycle after reset SHALL be ignored.
REQ-035 After rst_n rises, the first imem_req SHALL assert on the cycle after the first clock edge (the IDLE cycle).

Verification
REQ-036 Sequential: zero-wait memory, instr_ready=1, no control asserted -> imem_addr sequence 0,4,8,C; instr_valid pulses every 2nd cycle.
REQ-037 Wait states: ack delayed 3 cycles at pc=0x10 -> imem_req held 4 cycles with imem_addr=0x10; instruction updates only on the ack edge.
REQ-038 Back-pressure: instr_ready=0 for 5 cycles in HOLD -> instruction, pc and instr_valid=1 remain constant and imem_req=0.
REQ-039 Branches: pc=0x20, instruction[15:0]=16'hFFFE, beq=1, zero=1 -> next pc=0x1C; bne=0, zero=1 -> next pc=0x24; bne=0, zero=0, imm=3 -> next pc=0x30.
REQ-040 Jump priority: pc=0x4000_0000, Jump=1, beq=1, zero=1, instruction[25:0]=26'h10 -> next pc=0x4000_0040.
REQ-041 Reset and wrap: pc=0xFFFF_FFFC, sequential advance -> pc=0; then rst_n low mid-FETCH with ack pending -> pc=RESET_PC, instr_valid=0 and the ack ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: three-state fetch/hold sequencer with PC update for
// sequential flow, conditional branches (beq / active-low bne) and jumps.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        Jump,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero
);

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] IDLE  = 2'd0;
    localparam logic [ST_W-1:0] FETCH = 2'd1;
    localparam logic [ST_W-1:0] HOLD  = 2'd2;

    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    logic [ST_W-1:0] state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;

    logic [31:0] pc_plus4_c;
    logic [31:0] branch_off_c;
    logic [31:0] branch_tgt_c;
    logic [31:0] jump_tgt_c;
    logic        taken_c;
    logic [31:0] next_pc_c;

    // Next-PC selection; jump wins over any branch condition.
    always_comb begin
        pc_plus4_c   = pc_q + 32'd4;
        branch_off_c = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        branch_tgt_c = pc_plus4_c + branch_off_c;
        jump_tgt_c   = {pc_plus4_c[31:28], instr_q[25:0], 2'b00};
        taken_c      = (beq & zero) | (~bne & ~zero);
        if (Jump) begin
            next_pc_c = jump_tgt_c;
        end else if (taken_c) begin
            next_pc_c = branch_tgt_c;
        end else begin
            next_pc_c = pc_plus4_c;
        end
    end

    // Next-state and datapath update; control inputs only matter on HOLD handoff.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d    = {next_pc_c[31:2], 2'b00};
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d   = (state_d == FETCH);
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC_W;
            instr_q <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_c;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: sequential flow, wait states, back-pressure,
// branches, jump priority, PC wrap and asynchronous reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_ready = 1'b0;
    logic        Jump = 1'b0;
    logic        beq = 1'b0;
    logic        bne = 1'b1;
    logic        zero = 1'b0;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instruction, pc, pc_plus4;
    logic        j_imem_req, j_instr_valid;
    logic [31:0] j_imem_addr, j_instruction, j_pc, j_pc_plus4;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Low address bits of RESET_PC are deliberately non-zero; they must be forced to 00.
    fetch_unit #(.RESET_PC(32'h0000_0002)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .pc_plus4(pc_plus4),
        .Jump(Jump), .beq(beq), .bne(bne), .zero(zero)
    );

    fetch_unit #(.RESET_PC(32'h4000_0000)) u_dut_j (
        .clk(clk), .rst_n(rst_n),
        .imem_req(j_imem_req), .imem_addr(j_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(j_instruction), .instr_valid(j_instr_valid), .instr_ready(instr_ready),
        .pc(j_pc), .pc_plus4(j_pc_plus4),
        .Jump(Jump), .beq(beq), .bne(bne), .zero(zero)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: deliver word w with zero wait, then release it with the given controls.
    task automatic issue(input logic [31:0] w, input logic j, input logic b,
                         input logic bn, input logic z);
        imem_ack = 1'b1; imem_rdata = w; instr_ready = 1'b0;
        step();
        imem_ack = 1'b0; instr_ready = 1'b1; Jump = j; beq = b; bne = bn; zero = z;
        step();
        instr_ready = 1'b0; Jump = 1'b0; beq = 1'b0; bne = 1'b1; zero = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_total++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h want %h", pc, 32'h0); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else n_pass++;
        n_total++; if (instruction !== 32'h0) $display("FAIL rst_instr: got %h want 0", instruction); else n_pass++;
        rst_n = 1'b1;
        #2;
        n_total++; if (imem_req !== 1'b0) $display("FAIL idle_req: got %b want 0", imem_req); else n_pass++;
        step();
        n_total++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", imem_req); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL first_addr: got %h want 0", imem_addr); else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        imem_ack = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 32'(i * 4);
            imem_rdata = 32'hA000_0000 | a;
            n_total++; if (imem_req !== 1'b1 || imem_addr !== a)
                $display("FAIL seq_fetch[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, a); else n_pass++;
            n_total++; if (instr_valid !== 1'b0) $display("FAIL seq_gap[%0d]: got valid=%b want 0", i, instr_valid); else n_pass++;
            step();
            n_total++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instruction !== (32'hA000_0000 | a))
                $display("FAIL seq_hold[%0d]: got valid=%b req=%b instr=%h want 1 0 %h", i, instr_valid, imem_req, instruction, 32'hA000_0000 | a); else n_pass++;
            step();
        end
        imem_ack = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        imem_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instruction !== 32'hA000_000C)
                $display("FAIL wait[%0d]: got req=%b addr=%h instr=%h want 1 00000010 a000000c", k, imem_req, imem_addr, instruction); else n_pass++;
            step();
        end
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10)
            $display("FAIL wait_last: got req=%b addr=%h want 1 00000010", imem_req, imem_addr); else n_pass++;
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        n_total++; if (instruction !== 32'h1234_5678 || instr_valid !== 1'b1 || pc !== 32'h10)
            $display("FAIL wait_ack: got instr=%h valid=%b pc=%h want 12345678 1 00000010", instruction, instr_valid, pc); else n_pass++;
    endtask

    task automatic test_back_pressure();
        instr_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_0000; Jump = 1'b1; beq = 1'b1; zero = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_total++; if (instruction !== 32'h1234_5678 || pc !== 32'h10 || instr_valid !== 1'b1 || imem_req !== 1'b0)
                $display("FAIL bp[%0d]: got instr=%h pc=%h valid=%b req=%b want 12345678 00000010 1 0", k, instruction, pc, instr_valid, imem_req); else n_pass++;
            step();
        end
        imem_ack = 1'b0; Jump = 1'b0; beq = 1'b0; zero = 1'b0; instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        n_total++; if (pc !== 32'h14 || imem_req !== 1'b1 || instr_valid !== 1'b0)
            $display("FAIL bp_release: got pc=%h req=%b valid=%b want 00000014 1 0", pc, imem_req, instr_valid); else n_pass++;
    endtask

    task automatic test_branches();
        issue(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_total++; if (pc !== 32'h20) $display("FAIL br_setup: got pc=%h want 00000020", pc); else n_pass++;
        issue(32'h0000_FFFE, 1'b0, 1'b1, 1'b1, 1'b1);
        n_total++; if (pc !== 32'h1C) $display("FAIL br_beq: got pc=%h want 0000001c", pc); else n_pass++;
        issue(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(32'h0000_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        n_total++; if (pc !== 32'h24) $display("FAIL br_bne_nt: got pc=%h want 00000024", pc); else n_pass++;
        issue(32'h0000_FFFE, 1'b0, 1'b1, 1'b1, 1'b1);
        n_total++; if (pc !== 32'h20) $display("FAIL br_back: got pc=%h want 00000020", pc); else n_pass++;
        issue(32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++; if (pc !== 32'h30) $display("FAIL br_bne_t: got pc=%h want 00000030", pc); else n_pass++;
        issue(32'h0000_0003, 1'b0, 1'b1, 1'b1, 1'b0);
        n_total++; if (pc !== 32'h34) $display("FAIL br_beq_nt: got pc=%h want 00000034", pc); else n_pass++;
    endtask

    task automatic test_jump();
        rst_n = 1'b0;
        step();
        n_total++; if (j_pc !== 32'h4000_0000 || j_instruction !== 32'h0 || j_instr_valid !== 1'b0)
            $display("FAIL jrst: got pc=%h instr=%h valid=%b want 40000000 0 0", j_pc, j_instruction, j_instr_valid); else n_pass++;
        n_total++; if (pc !== 32'h0) $display("FAIL jrst_main: got pc=%h want 0", pc); else n_pass++;
        rst_n = 1'b1;
        step();
        n_total++; if (j_imem_req !== 1'b1 || j_imem_addr !== 32'h4000_0000 || j_pc_plus4 !== 32'h4000_0004)
            $display("FAIL jfetch: got req=%b addr=%h p4=%h want 1 40000000 40000004", j_imem_req, j_imem_addr, j_pc_plus4); else n_pass++;
        issue(32'h0000_0010, 1'b1, 1'b1, 1'b1, 1'b1);
        n_total++; if (j_pc !== 32'h4000_0040) $display("FAIL jump_prio: got pc=%h want 40000040", j_pc); else n_pass++;
        n_total++; if (pc !== 32'h40) $display("FAIL jump_low: got pc=%h want 00000040", pc); else n_pass++;
    endtask

    task automatic test_wrap_reset();
        issue(32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        n_total++; if (pc !== 32'h0) $display("FAIL wrap_j0: got pc=%h want 0", pc); else n_pass++;
        issue(32'h0000_FFFE, 1'b0, 1'b1, 1'b1, 1'b1);
        n_total++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0)
            $display("FAIL wrap_top: got pc=%h p4=%h want fffffffc 0", pc, pc_plus4); else n_pass++;
        issue(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_total++; if (pc !== 32'h0) $display("FAIL wrap_seq: got pc=%h want 0", pc); else n_pass++;
        issue(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_total++; if (pc !== 32'h4 || imem_req !== 1'b1) $display("FAIL pre_rst: got pc=%h req=%b want 4 1", pc, imem_req); else n_pass++;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (pc !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || instruction !== 32'h0)
            $display("FAIL async_rst: got pc=%h valid=%b req=%b instr=%h want 0 0 0 0", pc, instr_valid, imem_req, instruction); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_total++; if (instruction !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1 || pc !== 32'h0)
            $display("FAIL post_rst_ack: got instr=%h valid=%b req=%b pc=%h want 0 0 1 0", instruction, instr_valid, imem_req, pc); else n_pass++;
        step();
        imem_ack = 1'b0;
        n_total++; if (instruction !== 32'hBAD0_0001 || instr_valid !== 1'b1)
            $display("FAIL refetch: got instr=%h valid=%b want bad00001 1", instruction, instr_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_back_pressure();
        test_branches();
        test_jump();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
